// File: rtl/spi_master_mc.sv
// ---------------------------------------------------------------------------
// spi_master_mc
//
// Multi-chip-select SPI master running on the system clock. Every transfer
// carries its own SPI mode (cpol/cpha), half-period divider and target slave.
// The chip select may be kept asserted after a word so that several words
// form one frame; a held select is dropped by cs_release or by the next start.
//
// Ports
//   clk         system clock, all logic on the rising edge
//   rst         asynchronous active-high reset
//   start       transfer request, only looked at while idle
//   tx_data     word to send, captured with start
//   cs_sel      index of the target slave, captured with start
//   cpol, cpha  SPI mode, captured with start
//   clk_div     sclk half-period is clk_div+1 clk cycles, captured with start
//   cs_hold     keep the chip select asserted after this transfer
//   cs_release  drop a held chip select while idle
//   busy        transfer in progress
//   done        one-cycle pulse, rx_data is valid
//   rx_data     last received word, stable until the next done
//   sclk        registered SPI clock
//   mosi        registered SPI data out
//   miso        SPI data in
//   cs_n        registered one-hot active-low chip selects
// ---------------------------------------------------------------------------
module spi_master_mc #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CS     = 4,
    parameter int DIV_WIDTH  = 8,
    parameter int MSB_FIRST  = 1,
    localparam int CS_W      = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic [CS_W-1:0]       cs_sel,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic [DIV_WIDTH-1:0]  clk_div,
    input  logic                  cs_hold,
    input  logic                  cs_release,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso,
    output logic [NUM_CS-1:0]     cs_n
);

    localparam int CNT_W = $clog2(2 * DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_EDGE = CNT_W'(2 * DATA_WIDTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LEAD  = 2'd1;
    localparam logic [1:0] ST_XFER  = 2'd2;
    localparam logic [1:0] ST_TRAIL = 2'd3;

    logic [1:0]            state;
    logic [DIV_WIDTH-1:0]  div_cnt;
    logic [DIV_WIDTH-1:0]  div_l;
    logic [CNT_W-1:0]      edge_cnt;
    logic                  cpol_l;
    logic                  cpha_l;
    logic                  hold_l;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic [DATA_WIDTH-1:0] rx_shift;
    logic [NUM_CS-1:0]     cs_decode;
    logic                  tick;
    logic                  leading;
    logic                  last_trailing;

    // Bit that leaves the shifter next, honouring the shift direction.
    function automatic logic out_bit(input logic [DATA_WIDTH-1:0] d);
        return (MSB_FIRST != 0) ? d[DATA_WIDTH-1] : d[0];
    endfunction

    // Advance the transmit shifter by one bit.
    function automatic logic [DATA_WIDTH-1:0] shift_tx(input logic [DATA_WIDTH-1:0] d);
        if (MSB_FIRST != 0)
            return {d[DATA_WIDTH-2:0], 1'b0};
        else
            return {1'b0, d[DATA_WIDTH-1:1]};
    endfunction

    // Insert a sampled bit so that after DATA_WIDTH samples the word is in order.
    function automatic logic [DATA_WIDTH-1:0] shift_rx(input logic [DATA_WIDTH-1:0] d,
                                                       input logic b);
        if (MSB_FIRST != 0)
            return {d[DATA_WIDTH-2:0], b};
        else
            return {b, d[DATA_WIDTH-1:1]};
    endfunction

    // One-hot active-low decode of the requested slave; an index with no
    // matching line leaves every select high while the transfer still runs.
    always_comb begin
        cs_decode = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (cs_sel == CS_W'(i))
                cs_decode[i] = 1'b0;
        end
    end

    // tick marks the end of each H-cycle half period. edge_cnt holds the
    // number of sclk edges already produced, so an even count means the next
    // edge moves sclk away from cpol (a leading edge).
    assign tick          = (div_cnt == div_l);
    assign leading       = ~edge_cnt[0];
    assign last_trailing = (edge_cnt == LAST_EDGE - CNT_W'(1));

    // Transfer sequencer. LEAD waits one half period, XFER emits the 2W sclk
    // edges and then lets the final half period elapse, TRAIL waits one more
    // half period before reporting done. Drive happens on the edge where the
    // edge type matches cpha (leading for cpha=1, trailing for cpha=0);
    // sampling happens on the other edge type. For cpha=0 the first bit is
    // put on mosi at acceptance, so the shifter is pre-advanced by one bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            div_cnt  <= '0;
            div_l    <= '0;
            edge_cnt <= '0;
            cpol_l   <= 1'b0;
            cpha_l   <= 1'b0;
            hold_l   <= 1'b0;
            tx_shift <= '0;
            rx_shift <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rx_data  <= '0;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            cs_n     <= '1;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    sclk <= cpol;
                    if (start) begin
                        state    <= ST_LEAD;
                        busy     <= 1'b1;
                        div_cnt  <= '0;
                        edge_cnt <= '0;
                        div_l    <= clk_div;
                        cpol_l   <= cpol;
                        cpha_l   <= cpha;
                        hold_l   <= cs_hold;
                        rx_shift <= '0;
                        cs_n     <= cs_decode;
                        if (!cpha) begin
                            mosi     <= out_bit(tx_data);
                            tx_shift <= shift_tx(tx_data);
                        end else begin
                            mosi     <= 1'b0;
                            tx_shift <= tx_data;
                        end
                    end else if (cs_release) begin
                        cs_n <= '1;
                    end
                end

                ST_LEAD, ST_XFER: begin
                    if (!tick) begin
                        div_cnt <= div_cnt + DIV_WIDTH'(1);
                    end else begin
                        div_cnt <= '0;
                        if (edge_cnt == LAST_EDGE) begin
                            state <= ST_TRAIL;
                        end else begin
                            state    <= ST_XFER;
                            edge_cnt <= edge_cnt + CNT_W'(1);
                            sclk     <= leading ? ~cpol_l : cpol_l;
                            if (leading == cpha_l) begin
                                if (!last_trailing) begin
                                    mosi     <= out_bit(tx_shift);
                                    tx_shift <= shift_tx(tx_shift);
                                end
                            end else begin
                                rx_shift <= shift_rx(rx_shift, miso);
                            end
                        end
                    end
                end

                ST_TRAIL: begin
                    if (!tick) begin
                        div_cnt <= div_cnt + DIV_WIDTH'(1);
                    end else begin
                        div_cnt <= '0;
                        state   <= ST_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        rx_data <= rx_shift;
                        mosi    <= 1'b0;
                        if (!hold_l)
                            cs_n <= '1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
